muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer in the execute stage, beside the single-cycle ALU. It accepts one M-extension operation at a time and runs a one-bit-per-cycle shift-add or restoring-divide loop. It stalls the pipeline through `busy` and returns a registered 32-bit result with a one-cycle `done` pulse. A `kill` input lets branch/trap flush abandon an operation in flight.

---
 rtl/muldiv_seq_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 50 +++++
 rtl/muldiv_seq.sv | 174 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer:
// funct3 op codes, FSM states and the iteration count.
package muldiv_seq_pkg;

   localparam int         MULDIV_ITER      = 32;
   localparam logic [5:0] MULDIV_LAST_ITER = 6'(MULDIV_ITER - 1);

   typedef enum logic [2:0] {
      MULDIV_OP_MUL    = 3'b000,
      MULDIV_OP_MULH   = 3'b001,
      MULDIV_OP_MULHSU = 3'b010,
      MULDIV_OP_MULHU  = 3'b011,
      MULDIV_OP_DIV    = 3'b100,
      MULDIV_OP_DIVU   = 3'b101,
      MULDIV_OP_REM    = 3'b110,
      MULDIV_OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   // rs1 is treated as signed by every op except the unsigned ones
   function automatic logic in1_is_signed(input muldiv_op_e op);
      return op inside {MULDIV_OP_MUL, MULDIV_OP_MULH, MULDIV_OP_MULHSU,
                        MULDIV_OP_DIV, MULDIV_OP_REM};
   endfunction

   // MULHSU differs from MULH only in treating rs2 as unsigned
   function automatic logic in2_is_signed(input muldiv_op_e op);
      return op inside {MULDIV_OP_MUL, MULDIV_OP_MULH,
                        MULDIV_OP_DIV, MULDIV_OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply step or
// restoring-divide step. Divider path exists only with MULDIV_DIV_EN defined.
module muldiv_step
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   mcand,
   input  logic [XLEN-1:0]   opb,
   output logic [2*XLEN-1:0] acc_next,
   output logic [XLEN-1:0]   opb_next
);

   // Carry out of the upper-half add lands in bit 63 after the right shift.
   logic [XLEN:0] add_sum;
   assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (opb[0] ? {1'b0, mcand} : '0);

`ifdef MULDIV_DIV_EN
   // acc holds {remainder, quotient}; the dividend streams in MSB-first from opb.
   logic [XLEN:0]   rem_shift;
   logic [XLEN+1:0] trial;
   logic            unused_trial;

   assign rem_shift    = {acc[2*XLEN-1:XLEN], opb[XLEN-1]};
   assign trial        = {1'b0, rem_shift} - {2'b00, mcand};
   assign unused_trial = trial[XLEN];

   always_comb begin
      acc_next = {add_sum, acc[XLEN-1:1]};
      opb_next = opb >> 1;
      if (is_div) begin
         opb_next = opb << 1;
         if (!trial[XLEN+1]) begin
            acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end
   end
`else
   logic unused_step;

   assign acc_next    = {add_sum, acc[XLEN-1:1]};
   assign opb_next    = opb >> 1;
   assign unused_step = ^{is_div, acc[0]};
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (one bit per cycle, 34-cycle op).
// MULDIV_DIV_EN enables DIV/DIVU/REM/REMU; otherwise those ops return 0 at once.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] out
);

   muldiv_state_e     state_reg, state_next;
   muldiv_op_e        op_reg;
   logic              neg_reg;
   logic [XLEN-1:0]   mcand_reg;
   logic [XLEN-1:0]   opb_reg;
   logic [2*XLEN-1:0] acc_reg;
   logic [5:0]        cnt_reg;
   logic [XLEN-1:0]   out_reg;

   muldiv_op_e        op_in;
   logic              accept;
   logic              in1_neg, in2_neg, res_neg;
   logic [XLEN-1:0]   abs1, abs2;
   logic              special;
   logic [XLEN-1:0]   special_res;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   opb_step;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   fix_res;

   // Operand conditioning at accept time
   assign op_in   = muldiv_op_e'(op);
   assign in1_neg = in1_is_signed(op_in) & in1[XLEN-1];
   assign in2_neg = in2_is_signed(op_in) & in2[XLEN-1];
   assign abs1    = in1_neg ? -in1 : in1;
   assign abs2    = in2_neg ? -in2 : in2;

`ifdef MULDIV_DIV_EN
   logic div_zero, div_ovf;

   assign div_zero = (in2 == '0);
   assign div_ovf  = (op_in == MULDIV_OP_DIV || op_in == MULDIV_OP_REM)
                     && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
   assign special  = op_in[2] & (div_zero | div_ovf);
   // Remainder follows the dividend; product and quotient follow both signs.
   assign res_neg  = (op_in[2] & op_in[1]) ? in1_neg : (in1_neg ^ in2_neg);

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = op_in[1] ? in1 : '1;
      end else if (!op_in[1]) begin
         special_res = {1'b1, {(XLEN-1){1'b0}}};
      end
   end
`else
   assign special     = op_in[2];
   assign special_res = '0;
   assign res_neg     = in1_neg ^ in2_neg;
`endif

   // FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start && !kill) begin
               accept     = 1'b1;
               state_next = special ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (kill) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == MULDIV_LAST_ITER) begin
               state_next = ST_FIX;
            end
         end
         ST_FIX:  state_next = kill ? ST_IDLE : ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      busy = (state_reg == ST_CALC) || (state_reg == ST_FIX);
      done = (state_reg == ST_DONE);
   end

   muldiv_step #(
      .XLEN (XLEN)
   ) u_step (
      .is_div   (op_reg[2]),
      .acc      (acc_reg),
      .mcand    (mcand_reg),
      .opb      (opb_reg),
      .acc_next (acc_step),
      .opb_next (opb_step)
   );

   // Sign fixup and result selection, registered in FIX
   assign prod_fix = neg_reg ? -acc_reg : acc_reg;

`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0] div_sel, div_fix;

   assign div_sel = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
   assign div_fix = neg_reg ? -div_sel : div_sel;
`endif

   always_comb begin
      fix_res = '0;
      case (op_reg)
         MULDIV_OP_MUL: fix_res = prod_fix[XLEN-1:0];
         MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU:
            fix_res = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
         default: fix_res = div_fix;
`else
         default: fix_res = '0;
`endif
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg    <= MULDIV_OP_MUL;
         neg_reg   <= 1'b0;
         mcand_reg <= '0;
         opb_reg   <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         out_reg   <= '0;
      end else begin
         if (accept) begin
            op_reg    <= op_in;
            neg_reg   <= res_neg;
            mcand_reg <= abs2;
            opb_reg   <= abs1;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            if (special) begin
               out_reg <= special_res;
            end
         end
         if (state_reg == ST_CALC) begin
            acc_reg <= acc_step;
            opb_reg <= opb_step;
            cnt_reg <= cnt_reg + 6'd1;
         end
         if (state_reg == ST_FIX && !kill) begin
            out_reg <= fix_res;
         end
      end
   end

   assign out = out_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes reference results, a
// monitor pops and compares on every done pulse. Honours MULDIV_DIV_EN.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  op;
   logic [31:0] in1, in2;
   logic        busy, done;
   logic [31:0] out;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          c0;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic [31:0] last_out;

`ifdef MULDIV_DIV_EN
   localparam logic [2:0] RST_OP = 3'd4;
`else
   localparam logic [2:0] RST_OP = 3'd0;
`endif

   muldiv_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .in1   (in1),
      .in2   (in2),
      .kill  (kill),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb_, ub;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      ub  = longint'({32'd0, b});
      p   = '0;
      case (o)
         3'd0: begin p = sa * sb_; return p[31:0]; end
         3'd1: begin p = sa * sb_; return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
`ifdef MULDIV_DIV_EN
         3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb_; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
         3'd6: begin if (b == 0) return a; p = sa % sb_; return p[31:0]; end
         default: begin if (b == 0) return a; return a % b; end
`else
         default: return 32'd0;
`endif
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef MULDIV_DIV_EN
      if (o[2] && (b == 0)) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 34;
`else
      if (o[2]) return 1;
      if (a === 32'hx && b === 32'hx) return 0;
      return 34;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.res = model_res(o, a, b);
         e.lat = model_lat(o, a, b);
         e.c0  = cyc;
         e.op  = o;
         e.a   = a;
         e.b   = b;
         sb.push_back(e);
         last_out = e.res;
      end
      start = 1'b1;
      op    = o;
      in1   = a;
      in2   = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got %0d pending results after %0d cycles, expected 0",
                  sb.size(), budget);
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit trace);
      int lat;
      lat = model_lat(o, a, b);
      issue(o, a, b, 1'b1);
      if (trace) begin
         for (int k = 1; k <= 35; k++) begin
            check($sformatf("busy_op%0d_cyc%0d", o, k), {31'd0, busy},
                  {31'd0, (lat == 34 && k <= 33)});
            if (k < 35) @(negedge clk);
         end
      end
      wait_drain(60);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   logic [2:0]  d_op [10] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
   logic [31:0] d_a  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000};
   logic [31:0] d_b  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7,
                              32'd7, 32'd0, 32'd0, 32'hFFFFFFFF};

   initial begin
      exp_t e;
      rst   = 1'b1;
      start = 1'b0;
      kill  = 1'b0;
      op    = 3'd0;
      in1   = '0;
      in2   = '0;
      last_out = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_out", out, 32'd0);
      rst = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (done === 1'b1) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_done: got done=1 out=0x%08h, expected no done (cycle %0d)",
                           out, cyc);
               end else begin
                  e = sb.pop_front();
                  checks--;
                  check($sformatf("result_op%0d_%08h_%08h", e.op, e.a, e.b), out, e.res);
                  check($sformatf("latency_op%0d", e.op), 32'(cyc - e.c0), 32'(e.lat));
                  check("busy_at_done", {31'd0, busy}, 32'd0);
                  $display("op=%0d a=%08h b=%08h out=%08h exp=%08h lat=%0d",
                           e.op, e.a, e.b, out, e.res, cyc - e.c0);
               end
            end
         end
         begin
            repeat (80000) @(posedge clk);
            failures++;
            $display("FAIL watchdog: got no completion, expected finish within 80000 cycles");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      join_none

      // Signed MUL with per-cycle busy trace
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1);

      for (int i = 0; i < 10; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b1);

      // kill at cycle 10, restart at cycle 11 completes at 45
      issue(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy", {31'd0, busy}, 32'd0);
      check("kill_done", {31'd0, done}, 32'd0);
      check("kill_out_held", out, last_out);
      e.res = model_res(3'd3, 32'hDEADBEEF, 32'h00C0FFEE);
      e.lat = 34;
      e.c0  = cyc;
      e.op  = 3'd3;
      e.a   = 32'hDEADBEEF;
      e.b   = 32'h00C0FFEE;
      sb.push_back(e);
      last_out = e.res;
      start = 1'b1;
      op    = 3'd3;
      in1   = 32'hDEADBEEF;
      in2   = 32'h00C0FFEE;
      @(negedge clk);
      start = 1'b0;
      wait_drain(60);

      // rst at cycle 20
      issue(RST_OP, 32'hFFFFFFF9, 32'd2, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_out", out, 32'd0);
      rst = 1'b0;
      last_out = '0;

      // start during DONE must be ignored
      issue(3'd3, 32'hCAFEF00D, 32'h0000BEEF, 1'b1);
      repeat (33) @(negedge clk);
      start = 1'b1;
      op    = 3'd5;
      in1   = 32'd5;
      in2   = 32'd0;
      @(negedge clk);
      start = 1'b0;
      check("done_cycle_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("done_cycle_start_no_done", {31'd0, done}, 32'd0);
      check("done_cycle_start_out", out, last_out);
      repeat (5) @(negedge clk);
      wait_drain(5);

      for (int i = 0; i < 150; i++) begin
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
